// File: rtl/eth_txfifo_unpacker.sv
// Pops 32-bit words from the TX eth_fifo and serialises them MSB-byte-first
// into a length-delimited byte stream, flushing the FIFO on underrun or abort.
module eth_txfifo_unpacker #(
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int UNDERRUN_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    output logic                  fifo_clear,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  tx_sof,
    output logic                  tx_eof,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FETCH = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] word, word_nxt;
    logic [1:0]            idx, idx_nxt;
    logic [LEN_WIDTH-1:0]  remaining, remaining_nxt;
    logic                  first, first_nxt;
    logic [3:0]            wcnt, wcnt_nxt;
    logic                  done_nxt, underrun_nxt, clear_nxt;
    logic                  hs;

    // Valid/ready: tx_data, tx_sof and tx_eof are meaningful only while tx_valid
    // is high; a byte transfers on every rising edge with tx_valid & tx_ready,
    // and once raised tx_valid and the byte hold until that transfer or abort.
    assign tx_valid  = (state == S_SEND);
    assign tx_sof    = tx_valid & first;
    assign tx_eof    = tx_valid & (remaining == LEN_WIDTH'(1));
    assign fifo_read = (state == S_FETCH);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;
    assign hs        = tx_valid & tx_ready;

    always_comb begin
        tx_data = 8'h00;
        if (tx_valid) begin
            case (idx)
                2'd0:    tx_data = word[31:24];
                2'd1:    tx_data = word[23:16];
                2'd2:    tx_data = word[15:8];
                default: tx_data = word[7:0];
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        word_nxt      = word;
        idx_nxt       = idx;
        remaining_nxt = remaining;
        first_nxt     = first;
        wcnt_nxt      = wcnt;
        done_nxt      = 1'b0;
        underrun_nxt  = 1'b0;
        clear_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && frame_len != '0) begin
                    remaining_nxt = frame_len;
                    first_nxt     = 1'b1;
                    wcnt_nxt      = 4'd0;
                    state_nxt     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!fifo_empty) begin
                    wcnt_nxt  = 4'd0;
                    state_nxt = S_FETCH;
                end else if (!first && wcnt == 4'(UNDERRUN_LIMIT - 1)) begin
                    // The head of the frame is already on the wire: give up.
                    underrun_nxt = 1'b1;
                    clear_nxt    = 1'b1;
                    state_nxt    = S_IDLE;
                end else begin
                    wcnt_nxt = wcnt + 4'd1;
                end
            end
            S_FETCH: begin
                word_nxt  = fifo_data;
                idx_nxt   = 2'd0;
                state_nxt = S_SEND;
            end
            S_SEND: begin
                if (hs) begin
                    first_nxt     = 1'b0;
                    remaining_nxt = remaining - LEN_WIDTH'(1);
                    idx_nxt       = idx + 2'd1;
                    if (remaining == LEN_WIDTH'(1)) begin
                        // Leftover bytes of this word are dropped; it is already popped.
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (idx == 2'd3) begin
                        wcnt_nxt  = 4'd0;
                        state_nxt = fifo_empty ? S_WAIT : S_FETCH;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_nxt     = S_IDLE;
            remaining_nxt = remaining;
            idx_nxt       = idx;
            first_nxt     = first;
            done_nxt      = 1'b0;
            underrun_nxt  = 1'b0;
            clear_nxt     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            word       <= '0;
            idx        <= 2'd0;
            remaining  <= '0;
            first      <= 1'b0;
            wcnt       <= 4'd0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            fifo_clear <= 1'b0;
        end else begin
            state      <= state_nxt;
            word       <= word_nxt;
            idx        <= idx_nxt;
            remaining  <= remaining_nxt;
            first      <= first_nxt;
            wcnt       <= wcnt_nxt;
            done       <= done_nxt;
            underrun   <= underrun_nxt;
            fifo_clear <= clear_nxt;
        end
    end

endmodule

// File: tb/tb_eth_txfifo_unpacker.sv
// Bench for eth_txfifo_unpacker: table-driven frames, randomized frames against
// a byte-stream model, and hand sequences for abort, reset and ignored starts.
module tb_eth_txfifo_unpacker;

    logic        clk = 1'b0;
    logic        reset, start, abort, tx_ready;
    logic [15:0] frame_len;
    logic [31:0] fifo_data;
    logic        fifo_empty, fifo_read, fifo_clear;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_sof, tx_eof, busy, done, underrun;
    logic [1:0]  state_dbg;

    logic        push_en, tb_flush;
    logic [31:0] push_word;
    logic [31:0] fq[$];
    logic [31:0] wbuf[16];
    logic [7:0]  exp_q[$];

    int vectors = 0;
    int errors  = 0;

    int r_bytes, r_pops, r_done, r_under, r_clear;
    int r_hs_cyc, r_done_cyc, r_under_cyc;
    logic r_under_busy;

    typedef struct {
        int          len;
        int          nwords;
        logic [31:0] w0, w1, w2;
        int          ready_mode;
        bit          exp_underrun;
        int          exp_pops;
        int          exp_bytes;
        bit          exp_done;
    } vec_t;

    localparam int NT = 8;
    vec_t tab[NT];

    eth_txfifo_unpacker #(.DATA_WIDTH(32), .LEN_WIDTH(16), .UNDERRUN_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .frame_len(frame_len), .abort(abort),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
        .fifo_clear(fifo_clear), .tx_data(tx_data), .tx_valid(tx_valid), .tx_sof(tx_sof),
        .tx_eof(tx_eof), .tx_ready(tx_ready), .busy(busy), .done(done),
        .underrun(underrun), .state_dbg(state_dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // eth_fifo model: registered head word and empty flag
    always @(posedge clk) begin
        if (reset || fifo_clear || tb_flush) begin
            fq.delete();
        end else begin
            if (fifo_read && fq.size() > 0) void'(fq.pop_front());
            if (push_en) fq.push_back(push_word);
        end
        fifo_empty <= (fq.size() == 0);
        fifo_data  <= (fq.size() != 0) ? fq[0] : 32'h0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic flush();
        @(negedge clk) tb_flush = 1'b1;
        @(negedge clk) tb_flush = 1'b0;
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            push_en   = 1'b1;
            push_word = wbuf[i];
        end
        @(negedge clk) push_en = 1'b0;
    endtask

    task automatic run_frame(input int len, input int nw, input int push_delay,
                             input int mode, input bit busy_start);
        int pushed = 0;
        int nb = 0;
        int end_cyc = -1;
        logic prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h0;
        logic prev_eof = 1'b0;
        logic [31:0] t;
        exp_q.delete();
        for (int i = 0; i < len && i < 4 * nw; i++) begin
            t = wbuf[i / 4] >> (24 - 8 * (i % 4));
            exp_q.push_back(t[7:0]);
        end
        r_pops = 0; r_done = 0; r_under = 0; r_clear = 0;
        r_hs_cyc = -1; r_done_cyc = -1; r_under_cyc = -1; r_under_busy = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start     = (cyc == 0) || (busy_start && cyc == 3);
            frame_len = (cyc == 0) ? 16'(len) : 16'd2;
            if (cyc >= push_delay && pushed < nw) begin
                push_en   = 1'b1;
                push_word = wbuf[pushed];
                pushed++;
            end else begin
                push_en = 1'b0;
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 2 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (prev_stall) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, prev_data);
                check("hold_eof", tx_eof, prev_eof);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL extra_byte: got %0h expected none", tx_data);
                end else begin
                    check("byte", tx_data, exp_q.pop_front());
                end
                check("sof", tx_sof, nb == 0);
                check("eof", tx_eof, nb == len - 1);
                nb++;
                r_hs_cyc = cyc;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_eof   = tx_eof;
            if (fifo_read) r_pops++;
            if (fifo_clear) r_clear++;
            if (done) begin
                r_done++;
                r_done_cyc = cyc;
                if (end_cyc < 0) end_cyc = cyc;
            end
            if (underrun) begin
                r_under++;
                r_under_cyc  = cyc;
                r_under_busy = busy;
                if (end_cyc < 0) end_cyc = cyc;
            end
            if (end_cyc >= 0 && cyc >= end_cyc + 3) break;
        end
        start = 1'b0; push_en = 1'b0; tx_ready = 1'b0;
        r_bytes = nb;
        check("frame_timeout", end_cyc >= 0, 1);
        check("bytes_missing", exp_q.size(), 0);
    endtask

    task automatic check_frame(input string tag, input int nwords, input bit exp_under,
                               input int exp_pops, input int exp_bytes);
        check({tag, "_bytes"}, r_bytes, exp_bytes);
        check({tag, "_pops"}, r_pops, exp_pops);
        check({tag, "_done"}, r_done, !exp_under);
        check({tag, "_underrun"}, r_under, exp_under);
        check({tag, "_clear"}, r_clear, exp_under);
        check({tag, "_fifo_left"}, fq.size(), exp_under ? 0 : nwords - exp_pops);
        if (exp_under) begin
            check({tag, "_under_lat"}, r_under_cyc - r_hs_cyc, 5);
            check({tag, "_under_busy"}, r_under_busy, 0);
        end else begin
            check({tag, "_done_lat"}, r_done_cyc - r_hs_cyc, 1);
        end
    endtask

    initial begin
        int len, needed, nw, nb, pops;
        bit found, und;

        reset = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
        frame_len = 16'd0; push_en = 1'b0; push_word = 32'h0; tb_flush = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", tx_data, 0);
        check("rst_flags", {tx_sof, tx_eof, done, underrun, fifo_read, fifo_clear}, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b0;

        tab[0] = '{8,  2, 32'h01020304, 32'h05060708, 32'h0, 0, 1'b0, 2, 8, 1'b1};
        tab[1] = '{6,  2, 32'hAABBCCDD, 32'hEEFF1122, 32'h0, 0, 1'b0, 2, 6, 1'b1};
        tab[2] = '{8,  2, 32'h01020304, 32'h05060708, 32'h0, 1, 1'b0, 2, 8, 1'b1};
        tab[3] = '{12, 1, 32'hCAFEF00D, 32'h0,        32'h0, 0, 1'b1, 1, 4, 1'b0};
        tab[4] = '{1,  1, 32'h9ABCDEF0, 32'h0,        32'h0, 2, 1'b0, 1, 1, 1'b1};
        tab[5] = '{4,  2, 32'h11223344, 32'h55667788, 32'h0, 1, 1'b0, 1, 4, 1'b1};
        tab[6] = '{5,  2, 32'h11223344, 32'h55667788, 32'h0, 2, 1'b0, 2, 5, 1'b1};
        tab[7] = '{12, 3, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 0, 1'b0, 3, 12, 1'b1};

        for (int k = 0; k < NT; k++) begin
            wbuf[0] = tab[k].w0; wbuf[1] = tab[k].w1; wbuf[2] = tab[k].w2;
            run_frame(tab[k].len, tab[k].nwords, 0, tab[k].ready_mode, 1'b0);
            check_frame($sformatf("tab%0d", k), tab[k].nwords, tab[k].exp_underrun,
                        tab[k].exp_pops, tab[k].exp_bytes);
            flush();
        end

        // Late data: a long wait before the first word must not underrun;
        // a start pulse while busy must be ignored.
        wbuf[0] = 32'h01020304; wbuf[1] = 32'h05060708;
        run_frame(8, 2, 20, 0, 1'b1);
        check_frame("late", 2, 1'b0, 2, 8);
        flush();

        // Randomized frames against the byte-stream model
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
            len    = $urandom_range(1, 56);
            needed = (len + 3) / 4;
            nw     = needed + $urandom_range(0, 2);
            if (needed > 1 && $urandom_range(0, 4) == 0) nw = needed - 1;
            und  = (4 * nw < len);
            pops = (nw < needed) ? nw : needed;
            run_frame(len, nw, $urandom_range(0, 5), 2, 1'b0);
            check_frame("rand", nw, und, pops, und ? 4 * nw : len);
            flush();
        end

        // Zero-length start is ignored
        @(negedge clk); start = 1'b1; frame_len = 16'd0;
        @(negedge clk); start = 1'b0;
        #1;
        check("zero_len_busy", busy, 0);
        repeat (2) @(negedge clk);
        #1;
        check("zero_len_idle", {busy, done}, 0);

        // Abort while the third byte is offered
        wbuf[0] = 32'h01020304; wbuf[1] = 32'h05060708;
        preload(2);
        @(negedge clk); start = 1'b1; frame_len = 16'd8; tx_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        nb = 0; found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            #1;
            if (tx_valid) begin
                if (nb == 2) begin
                    check("abort_byte3", tx_data, 8'h03);
                    abort = 1'b1;
                    found = 1'b1;
                end else begin
                    check("abort_pre_byte", tx_data, nb + 1);
                    nb++;
                end
            end
        end
        check("abort_reached", found, 1);
        @(negedge clk); abort = 1'b0; tx_ready = 1'b0;
        #1;
        check("abort_valid", tx_valid, 0);
        check("abort_clear", fifo_clear, 1);
        check("abort_busy_done", {busy, done, underrun}, 0);
        @(negedge clk);
        #1;
        check("abort_clear_pulse", fifo_clear, 0);
        check("abort_fifo_empty", fq.size(), 0);
        check("abort_no_done", done, 0);

        // Asynchronous reset in the middle of SEND
        preload(2);
        @(negedge clk); start = 1'b1; frame_len = 16'd8; tx_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        nb = 0; found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            #1;
            if (tx_valid && nb == 2) found = 1'b1;
            else if (tx_valid) nb++;
        end
        check("rst_mid_reached", found, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_valid", tx_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_data", tx_data, 0);
        check("rst_mid_flags", {tx_sof, tx_eof, done, underrun, fifo_read, fifo_clear}, 0);
        check("rst_mid_state", state_dbg, 0);
        @(negedge clk); reset = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid_after", {busy, tx_valid}, 0);

        // Report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
